font_ram_writer: RTL and testbench
==================================

// Module: font_ram_writer
// PURPOSE
//  Loads glyph bitmaps into the writable character-generator RAM that the text
//  pixel path reads. Accepts a byte stream over a valid/ready handshake, one byte per
//  font row. Each byte is written to RAM address {char, row}, 8 rows per char.
//  Sits between the host/UART byte source and the char_gen RAM write port.
// PARAMETERS
//  CHAR_ADDR_W  6  character index width; 64 glyphs
//  ROW_W        3  font-row index width; 8 rows per glyph
//  DATA_W       8  glyph row width; bit 7 = leftmost pixel (col 0), stored unmodified
// PORTS
//  Clock        in   1   single system clock, all logic rising-edge
//  Reset        in   1   synchronous, active-high reset
//  Start        in   1   1-cycle request to begin a load; sampled only in IDLE
//  Start_char   in   6   first character index to write
//  Num_chars    in   7   glyph count, 1..64; 0 is treated as 64
//  Abort        in   1   cancel an active load
//  Data_in      in   8   glyph row byte
//  Data_valid   in   1   Data_in is valid
//  Data_ready   out  1   writer accepts Data_in this cycle
//  Ram_address  out  9   {char_index, row} write address
//  Ram_data     out  8   write data
//  Ram_wren     out  1   write enable, 1 cycle per byte
//  Busy         out  1   load in progress (LOAD or FLUSH)
//  Done         out  1   1-cycle pulse: final byte written
//  Aborted      out  1   1-cycle pulse: load cancelled by Abort
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; char/row/remaining counters 0.
//  FSM: IDLE -> LOAD on Start & ~Abort. The cycle after, char <= Start_char,
//   row <= 0, remaining <= Num_chars*8 (0 -> 512), 10-bit count.
//   LOAD -> FLUSH on accept of the final byte (remaining == 1).
//   FLUSH -> IDLE unconditionally after 1 cycle.
//   LOAD -> IDLE on Abort.
//  Data_ready = (state == LOAD) & ~Abort; decoded from state. Accept = Data_valid & Data_ready.
//  Write latency 1: accept in cycle N -> Ram_address/Ram_data registered and
//   Ram_wren = 1 in cycle N+1. Ram_wren = 0 in all other cycles; address/data hold.
//  Per accept: row++. On row 7 -> 0, char++. Char wraps 63 -> 0 (mod 64).
//   remaining--.
//  Done = 1 in FLUSH, coincident with the final Ram_wren. Busy = 0 from the next cycle.
//  Back-to-back: valid held high gives one byte per cycle, no bubbles.
//  Abort in LOAD: a same-cycle byte is not accepted and not written. Ram_wren from an
//   accept in the previous cycle still completes. Aborted pulses in the next cycle.
//   Done is not asserted.
//  Abort in FLUSH or IDLE has no effect. Start while Busy is ignored.
//  Start & Abort together in IDLE: stays IDLE, no pulse.
//  Reset mid-load: immediate return to IDLE, next-cycle outputs 0, no Done.
//   RAM contents are untouched beyond writes already issued.
// STRUCTURE
//  font_pkg: FONT_ROWS=8, CHAR_ADDR_W=6, ROW_W=3, DATA_W=8,
//   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH} font_wr_state_t.
//  Single flat module: FSM plus row/char/remaining counters. No sub-module.
//  The RAM is instantiated by the parent, not inside this block.
// TESTING
//  1 Start_char=0x05, Num_chars=1, 8 bytes 0x18,0x24,...,0x81 back-to-back
//    -> wren at addr 0x028..0x02F with matching data; Done with final write.
//  2 Start_char=0x3F, Num_chars=2 -> writes 0x1F8..0x1FF, then 0x000..0x007 (wrap);
//    16 writes total.
//  3 Data_valid toggled randomly, 30% duty, Num_chars=3 -> exactly 24 writes,
//    addresses contiguous, no duplicated or dropped bytes.
//  4 Abort in the cycle of byte 4 of a 1-char load -> writes only rows 0..2;
//    Aborted pulses once; Done never high; Data_ready=0 next cycle.
//  5 Num_chars=0 -> 512 writes covering 0x000..0x1FF; Start pulsed mid-load is ignored.
//  6 Reset asserted after byte 3 -> all outputs 0 next cycle; a new Start then loads
//    normally from row 0.

Source files
------------

// File: rtl/font_pkg.sv
// Shared types and widths for the character-generator RAM loader.
package font_pkg;

  localparam int FONT_ROWS   = 8;
  localparam int CHAR_ADDR_W = 6;
  localparam int ROW_W       = 3;
  localparam int DATA_W      = 8;
  localparam int ADDR_W      = CHAR_ADDR_W + ROW_W;
  localparam int NUM_W       = CHAR_ADDR_W + 1;
  localparam int COUNT_W     = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH} font_wr_state_t;

  // A glyph count of zero means the whole font, so the byte count tops out at 512.
  function automatic logic [COUNT_W-1:0] load_count(input logic [NUM_W-1:0] num);
    if (num == '0)
      return COUNT_W'(FONT_ROWS * (1 << CHAR_ADDR_W));
    else
      return {num, ROW_W'(0)};
  endfunction

endpackage

// File: rtl/font_ram_writer.sv
// Streams glyph row bytes into the char_gen RAM write port, one byte per
// font row, starting at {start_char, row 0}.
module font_ram_writer
  import font_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CHAR_ADDR_W-1:0] start_char,
  input  logic [NUM_W-1:0]       num_chars,
  input  logic                   abort,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   data_valid,
  output logic                   data_ready,
  output logic [ADDR_W-1:0]      ram_address,
  output logic [DATA_W-1:0]      ram_data,
  output logic                   ram_wren,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted
);

  font_wr_state_t state, next_state;

  logic [CHAR_ADDR_W-1:0] char_idx;
  logic [ROW_W-1:0]       row_idx;
  logic [COUNT_W-1:0]     remaining;

  logic accept;
  logic load_start;
  logic abort_load;

  always_ff @(posedge clock) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= next_state;
  end

  // Abort takes priority over a same-cycle byte, so that byte is never written.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    load_start = 1'b0;
    abort_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          next_state = S_LOAD;
          load_start = 1'b1;
        end
      end
      S_LOAD: begin
        if (abort) begin
          next_state = S_IDLE;
          abort_load = 1'b1;
        end else if (data_valid) begin
          accept = 1'b1;
          if (remaining == COUNT_W'(1))
            next_state = S_FLUSH;
        end
      end
      S_FLUSH: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  assign data_ready = (state == S_LOAD) && !abort;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_FLUSH);

  // The character index wraps modulo 64 on its own width.
  always_ff @(posedge clock) begin
    if (reset) begin
      char_idx  <= '0;
      row_idx   <= '0;
      remaining <= '0;
    end else if (load_start) begin
      char_idx  <= start_char;
      row_idx   <= '0;
      remaining <= load_count(num_chars);
    end else if (accept) begin
      row_idx   <= row_idx + 1'b1;
      remaining <= remaining - 1'b1;
      if (row_idx == ROW_W'(FONT_ROWS - 1))
        char_idx <= char_idx + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ram_wren    <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      aborted     <= 1'b0;
    end else begin
      ram_wren <= accept;
      aborted  <= abort_load;
      if (accept) begin
        ram_address <= {char_idx, row_idx};
        ram_data    <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_font_ram_writer.sv
// Directed self-checking bench for font_ram_writer: logs every RAM write and
// compares it against addresses and bytes the bench computes itself.
module tb_font_ram_writer;
  import font_pkg::*;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   start;
  logic [CHAR_ADDR_W-1:0] start_char;
  logic [NUM_W-1:0]       num_chars;
  logic                   abort;
  logic [DATA_W-1:0]      data_in;
  logic                   data_valid;
  logic                   data_ready;
  logic [ADDR_W-1:0]      ram_address;
  logic [DATA_W-1:0]      ram_data;
  logic                   ram_wren;
  logic                   busy;
  logic                   done;
  logic                   aborted;

  font_ram_writer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .start_char  (start_char),
    .num_chars   (num_chars),
    .abort       (abort),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted)
  );

  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [16:0] wr_q[$];
  int          wr_cycle[$];
  int          cycle_cnt   = 0;
  int          done_cnt    = 0;
  int          done_alone  = 0;
  int          aborted_cnt = 0;
  logic [7:0]  tx_bytes [512];

  always @(negedge clock) begin
    cycle_cnt++;
    if (ram_wren) begin
      wr_q.push_back({ram_address, ram_data});
      wr_cycle.push_back(cycle_cnt);
    end
    if (done) begin
      done_cnt++;
      if (!ram_wren) done_alone++;
    end
    if (aborted) aborted_cnt++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearLog();
    wr_q.delete();
    wr_cycle.delete();
    done_cnt    = 0;
    done_alone  = 0;
    aborted_cnt = 0;
  endtask

  task automatic fillBytes(input int seed);
    for (int i = 0; i < 512; i++) tx_bytes[i] = 8'(i * 13 + seed);
  endtask

  task automatic startLoad(input logic [5:0] sc, input logic [6:0] nc);
    @(posedge clock); #1;
    start      = 1'b1;
    start_char = sc;
    num_chars  = nc;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Offers bytes with the given valid duty (percent); poke_at pulses Start mid-load.
  task automatic applyStimulus(input int count, input int duty, input int poke_at);
    int idx = 0;
    int cyc = 0;
    while (idx < count && cyc < 4000) begin
      data_in    = tx_bytes[idx];
      data_valid = ($urandom_range(99) < duty);
      start      = (cyc == poke_at);
      if (cyc == poke_at) start_char = 6'h20;
      @(negedge clock);
      if (data_valid && data_ready) idx++;
      @(posedge clock); #1;
      cyc++;
    end
    data_valid = 1'b0;
    start      = 1'b0;
    checkOutput("stream_complete", idx, count);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput("idle_timeout", 32'(busy), 0);
  endtask

  task automatic checkWrites(input string tag, input logic [8:0] base, input int n);
    checkOutput({tag, "_count"}, wr_q.size(), n);
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      checkOutput({tag, "_addr"}, 32'(wr_q[i][16:8]), 32'(9'(base + i)));
      checkOutput({tag, "_data"}, 32'(wr_q[i][7:0]), 32'(tx_bytes[i]));
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    start_char = '0;
    num_chars  = '0;
    abort      = 1'b0;
    data_in    = '0;
    data_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("reset_outputs",
                32'({busy, done, aborted, ram_wren, data_ready, ram_address, ram_data}), 0);

    // Start together with Abort in IDLE must do nothing.
    @(posedge clock); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clock);
    checkOutput("start_abort_busy", 32'(busy), 0);
    checkOutput("start_abort_pulse", 32'(aborted), 0);

    // Test 1: single glyph at char 0x05, back-to-back bytes.
    tx_bytes[0] = 8'h18; tx_bytes[1] = 8'h24; tx_bytes[2] = 8'h42; tx_bytes[3] = 8'h42;
    tx_bytes[4] = 8'h7E; tx_bytes[5] = 8'h42; tx_bytes[6] = 8'h42; tx_bytes[7] = 8'h81;
    clearLog();
    startLoad(6'h05, 7'd1);
    applyStimulus(8, 100, -1);
    @(negedge clock);
    checkOutput("t1_done_final", 32'(done), 1);
    checkOutput("t1_wren_final", 32'(ram_wren), 1);
    checkOutput("t1_addr_final", 32'(ram_address), 32'h02F);
    @(negedge clock);
    checkOutput("t1_busy_after", 32'(busy), 0);
    checkOutput("t1_done_after", 32'(done), 0);
    checkWrites("t1", 9'h028, 8);
    if (wr_cycle.size() == 8)
      checkOutput("t1_no_bubbles", wr_cycle[7] - wr_cycle[0], 7);
    checkOutput("t1_done_count", done_cnt, 1);
    checkOutput("t1_done_with_wren", done_alone, 0);

    // Test 2: two glyphs starting at char 63 wrap to char 0.
    fillBytes(3);
    clearLog();
    startLoad(6'h3F, 7'd2);
    applyStimulus(16, 100, -1);
    waitIdle(10);
    checkWrites("t2", 9'h1F8, 16);
    checkOutput("t2_done_count", done_cnt, 1);

    // Test 3: sparse valid, three glyphs.
    fillBytes(91);
    clearLog();
    startLoad(6'h10, 7'd3);
    applyStimulus(24, 30, -1);
    waitIdle(10);
    checkWrites("t3", 9'h080, 24);
    checkOutput("t3_done_count", done_cnt, 1);

    // Test 4: abort while byte 4 is offered.
    fillBytes(200);
    clearLog();
    startLoad(6'h01, 7'd1);
    applyStimulus(3, 100, -1);
    data_in    = tx_bytes[3];
    data_valid = 1'b1;
    abort      = 1'b1;
    @(negedge clock);
    checkOutput("t4_ready_in_abort", 32'(data_ready), 0);
    @(posedge clock); #1;
    abort = 1'b0;
    @(negedge clock);
    checkOutput("t4_ready_after", 32'(data_ready), 0);
    checkOutput("t4_aborted_pulse", 32'(aborted), 1);
    checkOutput("t4_busy_after", 32'(busy), 0);
    @(posedge clock); #1;
    data_valid = 1'b0;
    repeat (3) @(negedge clock);
    checkWrites("t4", 9'h008, 3);
    checkOutput("t4_aborted_count", aborted_cnt, 1);
    checkOutput("t4_done_count", done_cnt, 0);

    // Test 5: zero glyph count loads the whole font; a mid-load Start is ignored.
    fillBytes(17);
    clearLog();
    startLoad(6'h00, 7'd0);
    applyStimulus(512, 100, 100);
    waitIdle(10);
    checkWrites("t5", 9'h000, 512);
    checkOutput("t5_done_count", done_cnt, 1);

    // Test 6: reset after byte 3, then a clean reload.
    fillBytes(55);
    clearLog();
    startLoad(6'h22, 7'd1);
    applyStimulus(3, 100, -1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checkOutput("t6_reset_outputs",
                32'({busy, done, aborted, ram_wren, data_ready, ram_address, ram_data}), 0);
    checkWrites("t6a", 9'h110, 3);
    checkOutput("t6_no_done", done_cnt, 0);
    clearLog();
    startLoad(6'h0A, 7'd1);
    applyStimulus(8, 100, -1);
    waitIdle(10);
    checkWrites("t6b", 9'h050, 8);
    checkOutput("t6b_done_count", done_cnt, 1);
    checkOutput("t6b_aborted_count", aborted_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
